// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART bundle for uart_tx_arbiter.
// master: the requesters and UART transmitter side (drives bytes and tx_busy).
// slave : the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              tx_busy;
    logic              abort;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_data, tx_send, abort
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_data, tx_send, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NREQ byte streams into one UART transmitter.
// A winner keeps the grant for a whole message (up to and including the byte
// flagged req_last). Each byte goes through FETCH -> SEND -> DRAIN.
// Optional build macro UART_ARB_TIMEOUT_EN: abandon a message (pulse abort)
// when the owner leaves req_valid low for TIMEOUT_CYCLES consecutive FETCH
// cycles. Without it FETCH waits forever and abort is tied low.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DRAIN} state_t;

    // Reject configurations outside the supported range at elaboration.
    if ((NREQ < 1) || (NREQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("uart_tx_arbiter: NREQ must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d;       // last message winner
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_send_q, tx_send_d;
    logic              last_q, last_d;     // current byte ends the message

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand;

    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic [PW-1:0]     win_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]     stall_q, stall_d;
    logic              abort_q, abort_d;
`endif

    // Round-robin search starting one past the previous winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Route the granted requester's byte/valid/last, and recover its index.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[8*i +: 8];
                win_idx   = PW'(i);
            end
        end
    end

    // Next-state logic for the message/byte sequencer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        tx_send_d = tx_send_q;
        last_d    = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d   = stall_q;
        abort_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                // tx_busy gate also protects a byte still in flight after reset
                if (pick_found && !bus.tx_busy) begin
                    for (int i = 0; i < NREQ; i++) begin
                        grant_d[i] = (pick_idx == PW'(i));
                    end
                    state_d = FETCH;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            FETCH: begin
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    tx_send_d = 1'b1;
                    last_d    = sel_last;
                    state_d   = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_d   = '0;
                end else if (stall_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // owner went quiet mid-message: drop it, rotate past it
                    abort_d = 1'b1;
                    ptr_d   = win_idx;
                    grant_d = '0;
                    state_d = IDLE;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
`endif
                end
            end
            SEND: begin
                if (bus.tx_busy) begin
                    tx_send_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = win_idx;
                    end else begin
                        state_d = FETCH;
`ifdef UART_ARB_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Sequencer registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PW'(NREQ - 1);
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
            last_q    <= last_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall counter and abort pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    assign bus.abort = abort_q;
`else
    assign bus.abort = 1'b0;
`endif

    assign bus.req_ready = (state_q == FETCH) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_send   = tx_send_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, TIMEOUT_CYCLES=16).
// A small UART model holds tx_busy for 10 cycles per tx_send; per-requester
// byte queues drive the request side; a monitor logs every tx_send rising edge.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(N)) bus ();

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // UART transmitter model
    int   busy_cnt = 0;
    logic auto_en;
    logic force_busy;
    always @(posedge clk) begin
        if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
        else if (bus.tx_send && auto_en)
            busy_cnt <= 10;
    end
    assign bus.tx_busy = (busy_cnt != 0) || force_busy;

    // Requester queues: {last, byte}
    logic [8:0] qmem [N][32];
    int         qwr [N];
    int         qrd [N] = '{default: 0};
    logic       acc_pend [N] = '{default: 1'b0};

    function automatic int nxt(input int i);
        return qrd[i] + (acc_pend[i] ? 1 : 0);
    endfunction

    // Present queue heads; a byte shown with ready high is taken at the next posedge
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            qrd[i]                 <= nxt(i);
            bus.req_valid[i]       <= nxt(i) < qwr[i];
            bus.req_data[8*i +: 8] <= qmem[i][nxt(i)][7:0];
            bus.req_last[i]        <= qmem[i][nxt(i)][8];
            acc_pend[i]            <= (nxt(i) < qwr[i]) && bus.req_ready[i];
        end
    end

    // Log of sent bytes
    logic [7:0]   log_data [64];
    logic [N-1:0] log_grant [64];
    int           log_n = 0;
    logic         send_d = 1'b0;
    always @(negedge clk) begin
        send_d <= bus.tx_send;
        if (bus.tx_send && !send_d) begin
            log_data[log_n]  <= bus.tx_data;
            log_grant[log_n] <= bus.grant;
            log_n            <= log_n + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic last);
        qmem[i][qwr[i]] = {last, b};
        qwr[i]++;
    endtask

    task automatic wait_log(input int n, input string tag);
        for (int c = 0; c < 300 && log_n < n; c++) step();
        chk(tag, log_n, n);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100 && !(bus.grant == '0 && !bus.tx_busy &&
             !bus.tx_send && bus.req_valid == '0); c++) step();
        chk(tag, (bus.grant == '0 && !bus.tx_busy && bus.req_valid == '0), 1);
    endtask

    initial begin
        int b;
        int cnt_a;
        int cnt_b;
        rst_n      = 1'b0;
        auto_en    = 1'b1;
        force_busy = 1'b0;
        for (int i = 0; i < N; i++) qwr[i] = 0;
        step();
        step();

        // reset state
        chk("rst_grant", bus.grant, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_send", bus.tx_send, 0);
        chk("rst_data", bus.tx_data, 0);
        chk("rst_abort", bus.abort, 0);
        rst_n = 1'b1;
        step();

        // simultaneous single-byte messages from 0,1,3
        b = log_n;
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(3, 8'hA3, 1'b1);
        wait_log(b + 3, "rot_count");
        chk("rot0_data", log_data[b], 8'hA0);
        chk("rot0_grant", log_grant[b], 4'b0001);
        chk("rot1_data", log_data[b+1], 8'hA1);
        chk("rot1_grant", log_grant[b+1], 4'b0010);
        chk("rot2_data", log_data[b+2], 8'hA3);
        chk("rot2_grant", log_grant[b+2], 4'b1000);

        // after winner 3 the search wraps to 0
        wait_idle("wrap_idle");
        b = log_n;
        push(1, 8'hB1, 1'b1);
        push(0, 8'hB0, 1'b1);
        wait_log(b + 2, "wrap_count");
        chk("wrap0_data", log_data[b], 8'hB0);
        chk("wrap0_grant", log_grant[b], 4'b0001);
        chk("wrap1_data", log_data[b+1], 8'hB1);
        chk("wrap1_grant", log_grant[b+1], 4'b0010);

        // "Hi\n" from requester 2, with first-byte latency
        wait_idle("hi_idle");
        b = log_n;
        push(2, 8'h48, 1'b0);
        push(2, 8'h69, 1'b0);
        push(2, 8'h0A, 1'b1);
        step();
        chk("lat_c0_send", bus.tx_send, 0);
        chk("lat_c0_grant", bus.grant, 0);
        step();
        chk("lat_c1_grant", bus.grant, 4'b0100);
        chk("lat_c1_ready", bus.req_ready, 4'b0100);
        chk("lat_c1_send", bus.tx_send, 0);
        step();
        chk("lat_c2_send", bus.tx_send, 1);
        chk("lat_c2_data", bus.tx_data, 8'h48);
        wait_log(b + 3, "hi_count");
        chk("hi0_data", log_data[b], 8'h48);
        chk("hi0_grant", log_grant[b], 4'b0100);
        chk("hi1_data", log_data[b+1], 8'h69);
        chk("hi1_grant", log_grant[b+1], 4'b0100);
        chk("hi2_data", log_data[b+2], 8'h0A);
        chk("hi2_grant", log_grant[b+2], 4'b0100);
        wait_idle("hi_end_idle");
        chk("hi_end_grant", bus.grant, 0);
        chk("hi_send_total", log_n, b + 3);

        // grant lock: requester 0 waits out requester 1's message
        wait_idle("lock_idle");
        b = log_n;
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b0);
        push(1, 8'h13, 1'b1);
        for (int c = 0; c < 20 && bus.grant != 4'b0010; c++) step();
        chk("lock_grant", bus.grant, 4'b0010);
        push(0, 8'hC0, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 200 && bus.grant == 4'b0010; c++) begin
            step();
            if (bus.grant == 4'b0010) begin
                cnt_a += int'(bus.req_ready[0]);
                cnt_b += int'(bus.req_valid[0]);
            end
        end
        chk("lock_ready0", cnt_a, 0);
        chk("lock_valid0_seen", (cnt_b > 0), 1);
        wait_log(b + 4, "lock_count");
        chk("lock0_data", log_data[b], 8'h11);
        chk("lock1_data", log_data[b+1], 8'h12);
        chk("lock2_data", log_data[b+2], 8'h13);
        chk("lock2_grant", log_grant[b+2], 4'b0010);
        chk("lock3_data", log_data[b+3], 8'hC0);
        chk("lock3_grant", log_grant[b+3], 4'b0001);

        // reset while SEND with the UART busy
        wait_idle("rs_idle");
        auto_en = 1'b0;
        b = log_n;
        push(3, 8'hD3, 1'b1);
        for (int c = 0; c < 20 && !bus.tx_send; c++) step();
        chk("rs_send_seen", bus.tx_send, 1);
        force_busy = 1'b1;
        rst_n      = 1'b0;
        #1;
        chk("rs_send", bus.tx_send, 0);
        chk("rs_grant", bus.grant, 0);
        chk("rs_ready", bus.req_ready, 0);
        step();
        rst_n = 1'b1;
        push(0, 8'hE0, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        repeat (6) begin
            step();
            cnt_a += int'(bus.tx_send);
            cnt_b += int'(bus.grant != '0);
        end
        chk("rs_hold_send", cnt_a, 0);
        chk("rs_hold_grant", cnt_b, 0);
        force_busy = 1'b0;
        auto_en    = 1'b1;
        wait_log(b + 2, "rs_count");
        chk("rs_after_data", log_data[b+1], 8'hE0);
        chk("rs_after_grant", log_grant[b+1], 4'b0001);

        // requester 0 stalls after one byte without last
        wait_idle("to_idle");
        b = log_n;
        push(0, 8'hF0, 1'b0);
        for (int c = 0; c < 20 && bus.grant != 4'b0001; c++) step();
        chk("to_grant", bus.grant, 4'b0001);
        push(1, 8'hF1, 1'b1);
        for (int c = 0; c < 30 && !bus.tx_busy; c++) step();
        chk("to_busy_rose", bus.tx_busy, 1);
        for (int c = 0; c < 30 && bus.tx_busy; c++) step();
        chk("to_busy_fell", bus.tx_busy, 0);
        cnt_a = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            cnt_a += int'(bus.abort);
        end
        chk("to_grant_k16", bus.grant, 4'b0001);
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_abort_early", cnt_a, 0);
        step();
        chk("to_abort_k17", bus.abort, 1);
        step();
        chk("to_abort_k18", bus.abort, 0);
        chk("to_next_grant", bus.grant, 4'b0010);
        wait_log(b + 2, "to_count");
        chk("to_next_data", log_data[b+1], 8'hF1);
        chk("to_next_dgrant", log_grant[b+1], 4'b0010);
`else
        repeat (24) begin
            step();
            cnt_a += int'(bus.abort);
        end
        chk("noto_abort", cnt_a, 0);
        chk("noto_grant", bus.grant, 4'b0001);
        chk("noto_count", log_n, b + 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: stall limit used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 Port clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous reset, active-low.
REQ-005 Port req_valid  input  NREQ: per-requester byte valid.
REQ-006 Port req_data  input  8*NREQ: per-requester byte; requester i occupies bits [8*i+7:8*i].
REQ-007 Port req_last  input  NREQ: marks the final byte of a message, qualified by req_valid.
REQ-008 Port req_ready  output  NREQ: byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 Port grant  output  NREQ: one-hot current message owner, or all-zero.
REQ-010 Port tx_data  output  8: byte to the UART transmitter.
REQ-011 Port tx_send  output  1: send strobe to the UART transmitter.
REQ-012 Port tx_busy  input  1: UART transmitter busy.
REQ-013 Port abort  output  1: one-cycle pulse when a message is abandoned on timeout.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, SEND and DRAIN.
REQ-015 IDLE: grant=0; when any req_valid=1 and tx_busy=0, the block SHALL pick a winner round-robin, starting at the index after the last winner, load grant one-hot and go to FETCH.
REQ-016 FETCH: req_ready SHALL equal grant (combinational, FETCH only); on accept, tx_data<=byte, tx_send<=1, latch req_last, go to SEND.
REQ-017 SEND: tx_send SHALL hold 1 until tx_busy=1 is sampled, then drop to 0 in the same transition to DRAIN.
REQ-018 DRAIN: wait for tx_busy=0; then go to IDLE if the latched last=1 (pointer <= winner), else go to FETCH.
REQ-019 tx_data SHALL be stable from tx_send rising until DRAIN exits.
REQ-020 Grant SHALL be locked for the whole message; req_valid of non-granted requesters SHALL be ignored and their req_ready held 0.
REQ-021 Latency: tx_send SHALL rise 2 clocks after the IDLE cycle that sampled req_valid=1 and tx_busy=0.
REQ-022 Simultaneous requests SHALL be served in rotation; no requester waits more than NREQ-1 messages.
REQ-023 A single-byte message (req_last=1 on the first byte) SHALL be legal.
REQ-024 NREQ=1 SHALL degrade to a pass-through sequencer with grant[0]=1 during messages.
REQ-025 Pointer wrap: after winner NREQ-1, the search SHALL start at index 0.

Reset
REQ-026 When rst_n=0, asynchronously: state=IDLE, grant=0, req_ready=0, tx_send=0, tx_data=0, abort=0, pointer such that requester 0 has first priority.
REQ-027 On reset mid-message, the partial message SHALL be dropped; after reset release, IDLE SHALL not grant while tx_busy=1, so a byte already in flight completes undisturbed.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: in FETCH, a counter SHALL count consecutive cycles with req_valid[winner]=0; on reaching TIMEOUT_CYCLES, abort=1 for one cycle, pointer<=winner, go to IDLE; the counter clears on every accept and on state entry.
REQ-029 Macro undefined: FETCH waits indefinitely, no counter is built, abort is tied 0.

Verification
REQ-030 NREQ=4, req 2 sends "Hi\n" (last on '\n'), model UART busy 10 cycles -> tx_data 0x48, 0x69, 0x0A in order, one tx_send per byte, grant=4'b0100 throughout, then 0.
REQ-031 Reqs 0,1,3 valid simultaneously with single-byte messages 0xA0, 0xA1, 0xA3 -> served in order 0, 1, 3; then req 0 again -> req 0 is served after req 3 (rotation).
REQ-032 Req 1 mid-message while req 0 asserts valid -> req 0 req_ready stays 0 until req 1 last byte DRAIN completes.
REQ-033 Assert rst_n=0 during SEND with tx_busy=1 -> tx_send=0 and grant=0 immediately; after release, no tx_send until tx_busy falls.
REQ-034 UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req 0 stops after first byte without last -> abort pulses exactly once, 16 cycles after the DRAIN->FETCH transition; req 1 granted next.
REQ-035 Macro undefined, same stimulus -> abort stays 0, grant stays 4'b0001 indefinitely.
